// File: rtl/lsu_handshake_unit_pkg.sv
// Shared types and helpers for the LSU handshake unit.
// Holds the op and state encodings, the default bus widths, and the
// size/alignment/byte-mask decode used by both the FSM and the lane logic.
package lsu_handshake_unit_pkg;

    localparam int LSU_ADDR_W    = 32;
    localparam int LSU_DATA_W    = 32;
    localparam int LSU_NUM_BYTES = LSU_DATA_W / 8;

    // Bits [1:0] give the access size (00 byte, 01 half, 10 word),
    // bit 2 marks a store and bit 3 marks a zero-extending load.
    typedef enum logic [3:0] {
        LSU_LD_B  = 4'b0000,
        LSU_LD_H  = 4'b0001,
        LSU_LD_W  = 4'b0010,
        LSU_LD_BU = 4'b1000,
        LSU_LD_HU = 4'b1001,
        LSU_ST_B  = 4'b0100,
        LSU_ST_H  = 4'b0101,
        LSU_ST_W  = 4'b0110
    } lsu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_OUT  = 2'd3
    } lsu_state_t;

    function automatic logic lsu_is_mem(input logic [3:0] op);
        case (op)
            LSU_LD_B, LSU_LD_H, LSU_LD_W, LSU_LD_BU, LSU_LD_HU,
            LSU_ST_B, LSU_ST_H, LSU_ST_W: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic lsu_is_store(input logic [3:0] op);
        case (op)
            LSU_ST_B, LSU_ST_H, LSU_ST_W: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op[1:0])
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [LSU_NUM_BYTES-1:0] lsu_byte_mask(input logic [3:0] op,
                                                               input logic [1:0] off);
        case (op[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic for the LSU.
// Ports:
//   i_op       captured lsu op
//   i_off      byte offset within the word (address bits [1:0])
//   i_st_data  store data, low bits significant
//   i_ld_word  raw word returned by memory
//   o_wmask    byte-lane write mask (0 for non-stores)
//   o_wdata    store data shifted onto its byte lanes
//   o_ld_data  load result shifted down and sign/zero extended
module lsu_data_align
    import lsu_handshake_unit_pkg::*;
(
    input  logic [3:0]               i_op,
    input  logic [1:0]               i_off,
    input  logic [LSU_DATA_W-1:0]    i_st_data,
    input  logic [LSU_DATA_W-1:0]    i_ld_word,
    output logic [LSU_NUM_BYTES-1:0] o_wmask,
    output logic [LSU_DATA_W-1:0]    o_wdata,
    output logic [LSU_DATA_W-1:0]    o_ld_data
);

    logic [4:0]            w_shamt;
    logic [LSU_DATA_W-1:0] w_ld_shift;
    logic                  w_ext_b;
    logic                  w_ext_h;

    assign w_shamt    = {i_off, 3'b000};
    assign o_wmask    = lsu_is_store(i_op) ? lsu_byte_mask(i_op, i_off) : '0;
    assign o_wdata    = i_st_data << w_shamt;
    assign w_ld_shift = i_ld_word >> w_shamt;

    // Bit 3 of the op selects zero extension (LD.BU / LD.HU).
    assign w_ext_b = ~i_op[3] & w_ld_shift[7];
    assign w_ext_h = ~i_op[3] & w_ld_shift[15];

    always_comb begin
        o_ld_data = w_ld_shift;
        case (i_op[1:0])
            2'b00:   o_ld_data = {{24{w_ext_b}}, w_ld_shift[7:0]};
            2'b01:   o_ld_data = {{16{w_ext_h}}, w_ld_shift[15:0]};
            default: o_ld_data = w_ld_shift;
        endcase
    end

endmodule

// File: rtl/lsu_handshake_unit.sv
// Memory-access stage between execute and writeback.
// Accepts one instruction at a time from EX, issues at most one memory
// request for loads/stores, waits for the response (bounded by a timeout),
// and presents the result to WB. Non-memory ops pass through in one cycle.
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_*                           EX handshake and captured instruction fields
//   flush                          cancel the in-flight instruction
//   mem_req_*                      request channel (valid/ready)
//   mem_resp_valid/rdata           response channel (read data or write ack)
//   out_*                          WB handshake and registered results
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | ready for a new instruction from EX
// REQ     | memory request presented, waiting for mem_req_ready
// RESP    | request accepted, waiting for response or timeout
// OUT     | result presented to WB, waiting for out_ready
module lsu_handshake_unit
    import lsu_handshake_unit_pkg::*;
#(
    parameter int ADDR_WIDTH     = LSU_ADDR_W,
    parameter int DATA_WIDTH     = LSU_DATA_W,
    parameter int NUM_OF_BYTES   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_WIDTH-1:0]     in_pc,
    input  logic [31:0]               in_inst,
    input  logic [3:0]                in_lsu_op,
    input  logic [DATA_WIDTH-1:0]     in_ex_result,
    input  logic [DATA_WIDTH-1:0]     in_lsu_data,
    input  logic                      in_rw_en,
    input  logic [REG_ADDR_WIDTH-1:0] in_rw_addr,
    input  logic                      flush,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    output logic                      mem_req_we,
    output logic [NUM_OF_BYTES-1:0]   mem_req_wmask,
    output logic [DATA_WIDTH-1:0]     mem_req_wdata,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_resp_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_WIDTH-1:0]     out_pc,
    output logic [31:0]               out_inst,
    output logic [REG_ADDR_WIDTH-1:0] out_rw_addr,
    output logic                      out_rw_en,
    output logic [DATA_WIDTH-1:0]     out_rw_data,
    output logic                      out_ale,
    output logic                      out_buserr,
    output logic [ADDR_WIDTH-1:0]     out_badv
);

    localparam int CNT_W = 16;

    lsu_state_t                r_state;
    lsu_state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0]     r_pc;
    logic [31:0]               r_inst;
    logic [REG_ADDR_WIDTH-1:0] r_rw_addr;
    logic                      r_rw_en;
    logic [3:0]                r_op;
    logic [DATA_WIDTH-1:0]     r_ex;
    logic [DATA_WIDTH-1:0]     r_sdata;
    logic                      r_cancel;
    logic [CNT_W-1:0]          r_cnt;

    logic [DATA_WIDTH-1:0]     r_out_data;
    logic                      r_out_rw_en;
    logic                      r_ale;
    logic                      r_buserr;
    logic [ADDR_WIDTH-1:0]     r_badv;

    logic                      w_accept;
    logic                      w_in_misal;
    logic                      w_timeout;
    logic                      w_req_store;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic [NUM_OF_BYTES-1:0]   w_wmask;
    logic [DATA_WIDTH-1:0]     w_wdata;
    logic [DATA_WIDTH-1:0]     w_ld_data;

    assign w_addr      = r_ex[ADDR_WIDTH-1:0];
    assign w_accept    = in_valid & in_ready;
    assign w_in_misal  = lsu_misaligned(in_lsu_op, in_ex_result[1:0]);
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_req_store = mem_req_valid & lsu_is_store(r_op);

    lsu_data_align u_align (
        .i_op      (r_op),
        .i_off     (r_ex[1:0]),
        .i_st_data (r_sdata),
        .i_ld_word (mem_resp_rdata),
        .o_wmask   (w_wmask),
        .o_wdata   (w_wdata),
        .o_ld_data (w_ld_data)
    );

    always_comb begin
        w_state_nxt   = r_state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Flush blocks acceptance in the same cycle, so it also lowers in_ready.
                in_ready = ~rst & ~flush;
                if (w_accept) begin
                    if (!lsu_is_mem(in_lsu_op) || w_in_misal) w_state_nxt = ST_OUT;
                    else                                      w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = ~flush;
                if (flush)              w_state_nxt = ST_IDLE;
                else if (mem_req_ready) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                // A handshaken transaction always runs to completion; a flush only
                // suppresses the writeback.
                if (mem_resp_valid || w_timeout)
                    w_state_nxt = (r_cancel || flush) ? ST_IDLE : ST_OUT;
            end
            ST_OUT: begin
                out_valid = ~flush;
                if (flush || out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_inst      <= '0;
            r_rw_addr   <= '0;
            r_rw_en     <= 1'b0;
            r_op        <= '0;
            r_ex        <= '0;
            r_sdata     <= '0;
            r_cancel    <= 1'b0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_rw_en <= 1'b0;
            r_ale       <= 1'b0;
            r_buserr    <= 1'b0;
            r_badv      <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pc        <= in_pc;
                        r_inst      <= in_inst;
                        r_rw_addr   <= in_rw_addr;
                        r_rw_en     <= in_rw_en;
                        r_op        <= in_lsu_op;
                        r_ex        <= in_ex_result;
                        r_sdata     <= in_lsu_data;
                        r_cancel    <= 1'b0;
                        r_cnt       <= '0;
                        r_out_data  <= '0;
                        r_out_rw_en <= 1'b0;
                        r_ale       <= 1'b0;
                        r_buserr    <= 1'b0;
                        r_badv      <= '0;
                        if (!lsu_is_mem(in_lsu_op)) begin
                            r_out_data  <= in_ex_result;
                            r_out_rw_en <= in_rw_en;
                        end else if (w_in_misal) begin
                            r_ale  <= 1'b1;
                            r_badv <= in_ex_result[ADDR_WIDTH-1:0];
                        end
                    end
                end
                ST_REQ: begin
                    if (!flush && mem_req_ready) r_cnt <= '0;
                end
                ST_RESP: begin
                    if (flush) r_cancel <= 1'b1;
                    // Response wins over a timeout landing on the same cycle.
                    if (mem_resp_valid) begin
                        r_out_data  <= lsu_is_store(r_op) ? '0 : w_ld_data;
                        r_out_rw_en <= r_rw_en;
                    end else if (w_timeout) begin
                        r_buserr <= 1'b1;
                        r_badv   <= w_addr;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_addr  = mem_req_valid ? {w_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_req_we    = w_req_store;
    assign mem_req_wmask = w_req_store ? w_wmask : '0;
    assign mem_req_wdata = w_req_store ? w_wdata : '0;

    assign out_pc      = r_pc;
    assign out_inst    = r_inst;
    assign out_rw_addr = r_rw_addr;
    assign out_rw_en   = r_out_rw_en;
    assign out_rw_data = r_out_data;
    assign out_ale     = r_ale;
    assign out_buserr  = r_buserr;
    assign out_badv    = r_badv;

endmodule

// File: tb/tb_lsu_handshake_unit.sv
module tb_lsu_handshake_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [3:0]  in_lsu_op;
    logic [31:0] in_ex_result;
    logic [31:0] in_lsu_data;
    logic        in_rw_en;
    logic [4:0]  in_rw_addr;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic [3:0]  mem_req_wmask;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [4:0]  out_rw_addr;
    logic        out_rw_en;
    logic [31:0] out_rw_data;
    logic        out_ale;
    logic        out_buserr;
    logic [31:0] out_badv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_handshake_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .in_lsu_op(in_lsu_op), .in_ex_result(in_ex_result), .in_lsu_data(in_lsu_data),
        .in_rw_en(in_rw_en), .in_rw_addr(in_rw_addr), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
        .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_rw_addr(out_rw_addr), .out_rw_en(out_rw_en),
        .out_rw_data(out_rw_data), .out_ale(out_ale), .out_buserr(out_buserr),
        .out_badv(out_badv)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and accept it; returns 1 when the handshake happened.
    task automatic present(input logic [3:0] op, input logic [31:0] ex, input logic [31:0] sd,
                           input logic rwen, output logic acc);
        in_valid     = 1'b1;
        in_lsu_op    = op;
        in_ex_result = ex;
        in_lsu_data  = sd;
        in_rw_en     = rwen;
        in_pc        = $urandom;
        in_inst      = $urandom;
        in_rw_addr   = 5'($urandom);
        #1;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL accept_bound: in_ready stayed %b, required 1 within 8 cycles", in_ready);
        end
    endtask

    // Full transaction against the reference model.
    // resp_d: RESP cycle (1-based) carrying the response; > TO means no response.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] ex,
                         input logic [31:0] sd, input logic rwen, input int req_wait,
                         input int resp_d, input logic [31:0] rdata, input int hold);
        int          kind;   // 0 non-memory, 1 load, 2 store
        int          sz;
        bit          sgn;
        int          off;
        bit          mis;
        bit          e_ale, e_be, e_en;
        logic [31:0] e_data, e_wdata, b, e_pc, e_inst;
        logic [3:0]  e_mask;
        logic [4:0]  e_rwa;
        logic        acc;
        int          n;

        kind = 0; sz = 4; sgn = 0;
        case (op)
            4'b0000: begin kind = 1; sz = 1; sgn = 1; end
            4'b0001: begin kind = 1; sz = 2; sgn = 1; end
            4'b0010: begin kind = 1; sz = 4; end
            4'b1000: begin kind = 1; sz = 1; end
            4'b1001: begin kind = 1; sz = 2; end
            4'b0100: begin kind = 2; sz = 1; end
            4'b0101: begin kind = 2; sz = 2; end
            4'b0110: begin kind = 2; sz = 4; end
            default: kind = 0;
        endcase
        off    = int'(ex % 4);
        mis    = (kind != 0) && ((ex % sz) != 0);
        e_mask = (kind == 2) ? 4'(((1 << sz) - 1) << off) : 4'b0000;
        e_wdata = sd << (8 * off);
        e_ale = 0; e_be = 0; e_en = rwen; e_data = 32'h0;

        present(op, ex, sd, rwen, acc);
        e_pc = in_pc; e_inst = in_inst; e_rwa = in_rw_addr;

        if (kind == 0) begin
            e_data = ex;
        end else if (mis) begin
            e_ale = 1; e_en = 0;
        end else begin
            for (int k = 0; k <= req_wait; k++) begin
                mem_req_ready = (k == req_wait);
                n_checks++;
                if ({mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask} !==
                    {1'b1, ex & 32'hFFFF_FFFC, kind == 2, e_mask}) begin
                    n_fail++;
                    $display("FAIL %s req: got v=%b a=%h we=%b m=%b, required v=1 a=%h we=%b m=%b",
                             tag, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask,
                             ex & 32'hFFFF_FFFC, kind == 2, e_mask);
                end
                if (kind == 2) begin
                    n_checks++;
                    if (mem_req_wdata !== e_wdata) begin
                        n_fail++;
                        $display("FAIL %s wdata: got %h, required %h", tag, mem_req_wdata, e_wdata);
                    end
                end
                tick();
            end
            mem_req_ready = 1'b0;
            n = (resp_d > TO) ? TO : resp_d;
            for (int j = 1; j <= n; j++) begin
                mem_resp_valid = (j == resp_d);
                mem_resp_rdata = (j == resp_d) ? rdata : $urandom;
                n_checks++;
                if ({mem_req_valid, out_valid} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL %s resp_wait%0d: got req_v=%b out_v=%b, required 0 0",
                             tag, j, mem_req_valid, out_valid);
                end
                tick();
            end
            mem_resp_valid = 1'b0;
            if (resp_d > TO) begin
                e_be = 1; e_en = 0;
            end else if (kind == 1) begin
                b = rdata >> (8 * off);
                if (sz == 1) begin
                    b = b % 256;
                    if (sgn && b >= 128) b = b + 32'hFFFF_FF00;
                end else if (sz == 2) begin
                    b = b % 65536;
                    if (sgn && b >= 32768) b = b + 32'hFFFF_0000;
                end
                e_data = b;
            end
        end

        for (int h = 0; h <= hold; h++) begin
            out_ready = (h == hold);
            n_checks++;
            if ({out_valid, out_rw_en, out_ale, out_buserr, in_ready, mem_req_valid} !==
                {1'b1, e_en, e_ale, e_be, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL %s out_ctl%0d: got v=%b en=%b ale=%b be=%b ir=%b rq=%b, required 1 %b %b %b 0 0",
                         tag, h, out_valid, out_rw_en, out_ale, out_buserr, in_ready,
                         mem_req_valid, e_en, e_ale, e_be);
            end
            n_checks++;
            if ({out_pc, out_inst, out_rw_addr} !== {e_pc, e_inst, e_rwa}) begin
                n_fail++;
                $display("FAIL %s out_copy: got pc=%h inst=%h rd=%0d, required pc=%h inst=%h rd=%0d",
                         tag, out_pc, out_inst, out_rw_addr, e_pc, e_inst, e_rwa);
            end
            n_checks++;
            if (e_ale || e_be) begin
                if (out_badv !== ex) begin
                    n_fail++;
                    $display("FAIL %s badv: got %h, required %h", tag, out_badv, ex);
                end
            end else if (out_rw_data !== e_data) begin
                n_fail++;
                $display("FAIL %s rw_data: got %h, required %h", tag, out_rw_data, e_data);
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s back_idle: got out_v=%b in_ready=%b, required 0 1", tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; in_pc = 0; in_inst = 0; in_lsu_op = 0; in_ex_result = 0; in_lsu_data = 0;
        in_rw_en = 0; in_rw_addr = 0; flush = 0; mem_req_ready = 0; mem_resp_valid = 0;
        mem_resp_rdata = 0; out_ready = 0;
        tick(); tick();
        n_checks++;
        if ({in_ready, mem_req_valid, out_valid, out_rw_en, out_ale, out_buserr, out_rw_data, out_badv, out_pc, mem_req_wmask} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got ir=%b rq=%b ov=%b en=%b ale=%b be=%b data=%h badv=%h pc=%h, required all 0",
                     in_ready, mem_req_valid, out_valid, out_rw_en, out_ale, out_buserr, out_rw_data, out_badv, out_pc);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b, required 1", in_ready);
        end
        tick();
    endtask

    task automatic test_directed();
        do_op("st_w", 4'b0110, 32'h1000_0004, 32'hDEAD_BEEF, 1'b0, 2, 3, 32'h0, 0);
        do_op("ld_b", 4'b0000, 32'h0000_2003, 32'h0, 1'b1, 0, 1, 32'h80FF_1234, 0);
        do_op("ld_bu", 4'b1000, 32'h0000_2003, 32'h0, 1'b1, 1, 2, 32'h80FF_1234, 1);
        do_op("ld_h", 4'b0001, 32'h0000_2002, 32'h0, 1'b1, 0, 1, 32'h80FF_1234, 0);
        do_op("st_h_ale", 4'b0101, 32'h0000_3001, 32'h1234, 1'b0, 0, 1, 32'h0, 0);
        do_op("ld_w_to", 4'b0010, 32'h0000_4000, 32'h0, 1'b1, 0, TO + 1, 32'h0, 0);
        do_op("ld_w_edge", 4'b0010, 32'h0000_4000, 32'h0, 1'b1, 0, TO, 32'hCAFE_F00D, 0);
        do_op("st_b_lane", 4'b0100, 32'h0000_5003, 32'h0000_00A5, 1'b0, 0, 1, 32'h0, 0);
        do_op("nonmem", 4'b1111, 32'h0000_0055, 32'h0, 1'b1, 0, 1, 32'h0, 3);
    endtask

    task automatic test_flush_resp();
        logic acc;
        present(4'b0010, 32'h0000_6000, 32'h0, 1'b1, acc);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        flush = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_resp_hold: got out_v=%b in_ready=%b, required 0 0", out_valid, in_ready);
        end
        tick();
        flush = 1'b0;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1111_2222;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_resp_wait: got out_v=%b in_ready=%b, required 0 0", out_valid, in_ready);
        end
        tick();
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL flush_resp_after%0d: got out_v=%b in_ready=%b, required 0 1", i, out_valid, in_ready);
            end
            tick();
        end
    endtask

    task automatic test_flush_req_out_idle();
        logic acc;
        present(4'b0110, 32'h0000_7000, 32'h0BAD_0BAD, 1'b0, acc);
        tick();
        flush = 1'b1;
        mem_req_ready = 1'b1;
        #1;
        n_checks++;
        if (mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_req_drop: got mem_req_valid=%b, required 0", mem_req_valid);
        end
        tick();
        flush = 1'b0;
        mem_req_ready = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, mem_req_valid, out_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL flush_req_idle: got ir=%b rq=%b ov=%b, required 1 0 0", in_ready, mem_req_valid, out_valid);
        end
        present(4'b1110, 32'h0000_0077, 32'h0, 1'b1, acc);
        flush = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_out_drop: got out_valid=%b, required 0", out_valid);
        end
        tick();
        flush = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_out_idle: got ir=%b ov=%b, required 1 0", in_ready, out_valid);
        end
        in_valid = 1'b1;
        in_lsu_op = 4'b1111;
        flush = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_block: got in_ready=%b, required 0", in_ready);
        end
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, mem_req_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL flush_idle_none: got ir=%b ov=%b rq=%b, required 1 0 0", in_ready, out_valid, mem_req_valid);
        end
        tick();
    endtask

    task automatic test_reset_midreq();
        logic acc;
        present(4'b0010, 32'h0000_8000, 32'h0, 1'b1, acc);
        n_checks++;
        if (mem_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got mem_req_valid=%b, required 1", mem_req_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_req_valid, out_valid, in_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_drop: got rq=%b ov=%b ir=%b, required 0 0 0", mem_req_valid, out_valid, in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, mem_req_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_mid_idle: got ir=%b rq=%b, required 1 0", in_ready, mem_req_valid);
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0]  ops [11];
        logic [3:0]  op;
        logic [31:0] ex;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b1000, 4'b1001, 4'b0100, 4'b0101,
                4'b0110, 4'b1111, 4'b0011, 4'b1100};
        for (int t = 0; t < 60; t++) begin
            op = ops[$urandom_range(0, 10)];
            ex = $urandom;
            do_op("rand", op, ex, $urandom, 1'($urandom), int'($urandom_range(0, 2)),
                  int'($urandom_range(1, TO + 1)), $urandom, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush_resp();
        test_flush_req_out_idle();
        test_reset_midreq();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
